// File: rtl/fsmd_pkg.sv
// rtl/fsmd_pkg.sv - shared register-select, data-select and ALU-function types for the FSMD datapath and controller
package fsmd_pkg;

    typedef enum logic [2:0] {
        R0 = 3'd0, R1 = 3'd1, R2 = 3'd2, R3 = 3'd3,
        R4 = 3'd4, R5 = 3'd5, R6 = 3'd6, R7 = 3'd7
    } rsel_t;

    typedef enum logic {
        DSEL_ALU = 1'b0,
        DSEL_EXT = 1'b1
    } dsel_t;

    typedef enum logic [3:0] {
        ALU_MOVA = 4'd0,
        ALU_MOVB = 4'd1,
        ALU_INC  = 4'd2,
        ALU_DEC  = 4'd3,
        ALU_ADD  = 4'd4,
        ALU_SUB  = 4'd5,
        ALU_MUL  = 4'd6,
        ALU_AND  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_XOR  = 4'd9,
        ALU_NOT  = 4'd10,
        ALU_CLR  = 4'd11
    } alufunc_t;

    localparam int NUM_REGS = 8;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational function unit; all arithmetic wraps modulo 2^DW
module alu
    import fsmd_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  alufunc_t      fsel,
    output logic [DW-1:0] y
);

    localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};

    always_comb begin
        y = '0;
        case (fsel)
            ALU_MOVA: y = a;
            ALU_MOVB: y = b;
            ALU_INC:  y = a + ONE;
            ALU_DEC:  y = a - ONE;
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_MUL:  y = a * b;
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_XOR:  y = a ^ b;
            ALU_NOT:  y = ~a;
            ALU_CLR:  y = '0;
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/datapath.sv
// rtl/datapath.sv - 8-entry register file, ALU, write mux, flags and captured result output
module datapath
    import fsmd_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          srst_n,
    input  logic          we_in,
    input  rsel_t         rsel_in,
    input  rsel_t         asel_in,
    input  rsel_t         bsel_in,
    input  dsel_t         dsel_in,
    input  alufunc_t      fsel_in,
    input  logic [DW-1:0] ext_in,
    input  logic          done_in,
    output logic          n_out,
    output logic          z_out,
    output logic [DW-1:0] dout_out,
    output logic          valid_out
);

    logic [DW-1:0] regs [NUM_REGS];
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic [DW-1:0] alu_y;
    logic [DW-1:0] wdata;

    // Operands come straight from the array: a same-cycle write is not bypassed.
    assign op_a = regs[asel_in];
    assign op_b = regs[bsel_in];

    alu #(.DW(DW)) u_alu (
        .a    (op_a),
        .b    (op_b),
        .fsel (fsel_in),
        .y    (alu_y)
    );

    assign wdata = (dsel_in == DSEL_EXT) ? ext_in : alu_y;
    assign n_out = alu_y[DW-1];
    assign z_out = (alu_y == '0);

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            dout_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            if (we_in) begin
                regs[rsel_in] <= wdata;
            end
            if (done_in) begin
                dout_out <= alu_y;
            end
            valid_out <= done_in;
        end
    end

endmodule
